// File: rtl/contador_bcd_mod_updown_pkg.sv
// Shared BCD counter definitions: digit width, largest digit, BCD-to-binary helper.
package contador_bcd_mod_updown_pkg;

  localparam int unsigned       BCD_W   = 4;
  localparam logic [BCD_W-1:0]  BCD_MAX = 4'd9;
  localparam int unsigned       BIN_W   = 7;

  // Two BCD digits to binary; valid for digits 0..9 (result 0..99).
  function automatic logic [BIN_W-1:0] bcd2bin(input logic [BCD_W-1:0] d1,
                                               input logic [BCD_W-1:0] d0);
    return BIN_W'(BIN_W'(d1) * BIN_W'(10) + BIN_W'(d0));
  endfunction

endpackage

// File: rtl/contador_bcd_mod_updown_detector_flanco.sv
// Rising-edge detector; history resets to 1 so a level already high at reset
// release is not a tick. EDGE_DET=0 passes the level straight through.
module contador_bcd_mod_updown_detector_flanco #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic tick_c
);

  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= 1'b1;
    else        hist_q <= sig_i;
  end

  assign tick_c = EDGE_DET ? (sig_i & ~hist_q) : sig_i;

endmodule

// File: rtl/contador_bcd_mod_updown.sv
// Modulo-MOD up/down counter with two BCD digits, synchronous checked load and
// carry/borrow pulses for chaining (upper stage uses EDGE_DET=0).
module contador_bcd_mod_updown
  import contador_bcd_mod_updown_pkg::*;
#(
  parameter int unsigned MOD      = 60,
  parameter bit          EDGE_DET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enUP,
  input  logic             enDOWN,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d1,
  input  logic [BCD_W-1:0] load_d0,
  output logic [BCD_W-1:0] digit1,
  output logic [BCD_W-1:0] digit0,
  output logic [BIN_W-1:0] count_bin,
  output logic             carry,
  output logic             borrow,
  output logic             load_err
);

  localparam int unsigned      TOP    = MOD - 1;
  localparam logic [BCD_W-1:0] TOP_D1 = BCD_W'(TOP / 10);
  localparam logic [BCD_W-1:0] TOP_D0 = BCD_W'(TOP % 10);
  localparam int unsigned      LBIN_W = BIN_W + 1;

  logic             up_t, dn_t;
  logic [BCD_W-1:0] d1_q, d0_q, d1_d, d0_d;
  logic             carry_q, carry_d, borrow_q, borrow_d, lerr_q, lerr_d;
  logic             cur_ok, ld_ok;
  logic [BCD_W-1:0] c1, c0;
  logic [BIN_W-1:0] cur_bin;
  logic [LBIN_W-1:0] ld_bin;

  contador_bcd_mod_updown_detector_flanco #(.EDGE_DET(EDGE_DET)) u_det_up (
    .clk    (clk),
    .rst_n  (reset),
    .sig_i  (enUP),
    .tick_c (up_t)
  );

  contador_bcd_mod_updown_detector_flanco #(.EDGE_DET(EDGE_DET)) u_det_dn (
    .clk    (clk),
    .rst_n  (reset),
    .sig_i  (enDOWN),
    .tick_c (dn_t)
  );

  // Next state: load > simultaneous up/down (hold) > up > down > hold.
  always_comb begin
    d1_d     = d1_q;
    d0_d     = d0_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    lerr_d   = 1'b0;

    // An out-of-range state is treated as 0 by the next tick.
    cur_ok  = (d1_q <= BCD_MAX) && (d0_q <= BCD_MAX) &&
              (bcd2bin(d1_q, d0_q) < BIN_W'(MOD));
    c1      = cur_ok ? d1_q : '0;
    c0      = cur_ok ? d0_q : '0;
    cur_bin = bcd2bin(c1, c0);

    ld_bin = LBIN_W'(LBIN_W'(load_d1) * LBIN_W'(10) + LBIN_W'(load_d0));
    ld_ok  = (load_d1 <= BCD_MAX) && (load_d0 <= BCD_MAX) && (ld_bin < LBIN_W'(MOD));

    if (load) begin
      if (ld_ok) begin
        d1_d = load_d1;
        d0_d = load_d0;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (up_t && !dn_t) begin
      if (cur_bin == BIN_W'(TOP)) begin
        d1_d    = '0;
        d0_d    = '0;
        carry_d = 1'b1;
      end else if (c0 == BCD_MAX) begin
        d1_d = c1 + BCD_W'(1);
        d0_d = '0;
      end else begin
        d1_d = c1;
        d0_d = c0 + BCD_W'(1);
      end
    end else if (dn_t && !up_t) begin
      if (cur_bin == '0) begin
        d1_d     = TOP_D1;
        d0_d     = TOP_D0;
        borrow_d = 1'b1;
      end else if (c0 == '0) begin
        d1_d = c1 - BCD_W'(1);
        d0_d = BCD_MAX;
      end else begin
        d1_d = c1;
        d0_d = c0 - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d1_q     <= '0;
      d0_q     <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      d1_q     <= d1_d;
      d0_q     <= d0_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      lerr_q   <= lerr_d;
    end
  end

  assign digit1    = d1_q;
  assign digit0    = d0_q;
  assign count_bin = bcd2bin(d1_q, d0_q);
  assign carry     = carry_q;
  assign borrow    = borrow_q;
  assign load_err  = lerr_q;

endmodule

// File: tb/tb_contador_bcd_mod_updown.sv
// Bench: MOD=60 edge-detect counter and MOD=24 level (cascade-mode) counter
// against an arithmetic value model, with directed cases and a random soak.
module tb_contador_bcd_mod_updown;

  logic       clk = 1'b0;
  logic       reset;
  logic       enUP, enDOWN, load;
  logic [3:0] load_d1, load_d0;
  logic [3:0] digit1, digit0;
  logic [6:0] count_bin;
  logic       carry, borrow, load_err;

  logic       c_up, c_dn, c_ld;
  logic [3:0] c_d1, c_d0;
  logic [3:0] c_digit1, c_digit0;
  logic [6:0] c_bin;
  logic       c_carry, c_borrow, c_lerr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: plain integer values plus previous enable levels.
  int m_val, c_val;
  bit m_pu, m_pd;
  bit m_cy, m_bo, m_le, c_cy, c_bo, c_le;
  int casc_carries;

  contador_bcd_mod_updown #(.MOD(60), .EDGE_DET(1'b1)) u_dut (
    .clk(clk), .reset(reset), .enUP(enUP), .enDOWN(enDOWN), .load(load),
    .load_d1(load_d1), .load_d0(load_d0), .digit1(digit1), .digit0(digit0),
    .count_bin(count_bin), .carry(carry), .borrow(borrow), .load_err(load_err)
  );

  contador_bcd_mod_updown #(.MOD(24), .EDGE_DET(1'b0)) u_casc (
    .clk(clk), .reset(reset), .enUP(c_up), .enDOWN(c_dn), .load(c_ld),
    .load_d1(c_d1), .load_d0(c_d0), .digit1(c_digit1), .digit0(c_digit0),
    .count_bin(c_bin), .carry(c_carry), .borrow(c_borrow), .load_err(c_lerr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; c_val = 0;
    m_pu = 1'b1; m_pd = 1'b1;
    {m_cy, m_bo, m_le, c_cy, c_bo, c_le} = '0;
  endtask

  // One clock edge of both counters, from the rules in value arithmetic.
  task automatic model_step();
    bit ut, dt;
    int lv;
    ut = enUP & ~m_pu;
    dt = enDOWN & ~m_pd;
    m_pu = enUP;
    m_pd = enDOWN;
    {m_cy, m_bo, m_le} = '0;
    if (load) begin
      lv = int'(load_d1) * 10 + int'(load_d0);
      if (load_d1 <= 9 && load_d0 <= 9 && lv < 60) m_val = lv;
      else m_le = 1'b1;
    end else if (ut && !dt) begin
      m_cy  = (m_val == 59);
      m_val = (m_val + 1) % 60;
    end else if (dt && !ut) begin
      m_bo  = (m_val == 0);
      m_val = (m_val + 59) % 60;
    end

    {c_cy, c_bo, c_le} = '0;
    if (c_ld) begin
      lv = int'(c_d1) * 10 + int'(c_d0);
      if (c_d1 <= 9 && c_d0 <= 9 && lv < 24) c_val = lv;
      else c_le = 1'b1;
    end else if (c_up && !c_dn) begin
      c_cy  = (c_val == 23);
      c_val = (c_val + 1) % 24;
    end else if (c_dn && !c_up) begin
      c_bo  = (c_val == 0);
      c_val = (c_val + 23) % 24;
    end
  endtask

  task automatic check_all();
    chk("m60_digit1", 32'(digit1), 32'(m_val / 10));
    chk("m60_digit0", 32'(digit0), 32'(m_val % 10));
    chk("m60_bin",    32'(count_bin), 32'(m_val));
    chk("m60_range",  32'(count_bin < 7'd60), 32'd1);
    chk("m60_carry",  32'(carry),  32'(m_cy));
    chk("m60_borrow", 32'(borrow), 32'(m_bo));
    chk("m60_lerr",   32'(load_err), 32'(m_le));
    chk("m24_digit1", 32'(c_digit1), 32'(c_val / 10));
    chk("m24_digit0", 32'(c_digit0), 32'(c_val % 10));
    chk("m24_bin",    32'(c_bin), 32'(c_val));
    chk("m24_range",  32'(c_bin < 7'd24), 32'd1);
    chk("m24_carry",  32'(c_carry),  32'(c_cy));
    chk("m24_borrow", 32'(c_borrow), 32'(c_bo));
    chk("m24_lerr",   32'(c_lerr), 32'(c_le));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [3:0] d1, input logic [3:0] d0);
    load = 1'b1; load_d1 = d1; load_d0 = d0;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    enUP = 1'b1; enDOWN = 1'b0; load = 1'b0; load_d1 = '0; load_d0 = '0;
    c_up = 1'b0; c_dn = 1'b0; c_ld = 1'b0; c_d1 = '0; c_d0 = '0;
    model_reset();
    #1;
    check_all();

    // 1: enable high through reset release does not count
    #12 reset = 1'b1;
    repeat (3) cyc();
    chk("t1_hold_bin", 32'(count_bin), 32'd0);
    enUP = 1'b0; cyc();
    enUP = 1'b1; cyc();
    chk("t1_first_up", 32'({digit1, digit0}), 32'h01);
    enUP = 1'b0; cyc();

    // 2: 5/8 -> 5/9 -> 0/0 with one carry
    do_load(4'd5, 4'd8);
    enUP = 1'b1; cyc(); enUP = 1'b0; cyc();
    chk("t2_59", 32'({digit1, digit0}), 32'h59);
    enUP = 1'b1; cyc();
    chk("t2_wrap", 32'({digit1, digit0}), 32'h00);
    chk("t2_carry", 32'(carry), 32'd1);
    enUP = 1'b0; cyc();
    chk("t2_carry_gone", 32'(carry), 32'd0);

    // 3: borrow at 0 -> 59, then plain decrement
    enDOWN = 1'b1; cyc();
    chk("t3_59", 32'({digit1, digit0}), 32'h59);
    chk("t3_borrow", 32'(borrow), 32'd1);
    enDOWN = 1'b0; cyc();
    enDOWN = 1'b1; cyc();
    chk("t3_58", 32'({digit1, digit0}), 32'h58);
    chk("t3_no_borrow", 32'(borrow), 32'd0);
    enDOWN = 1'b0; cyc();

    // 4: simultaneous edges hold; load wins over an up edge
    do_load(4'd2, 4'd3);
    enUP = 1'b1; enDOWN = 1'b1; cyc();
    chk("t4_both_hold", 32'(count_bin), 32'd23);
    enUP = 1'b0; enDOWN = 1'b0; cyc();
    do_load(4'd1, 4'd0);
    enUP = 1'b1; do_load(4'd4, 4'd4);
    chk("t4_load_wins", 32'({digit1, digit0}), 32'h44);
    enUP = 1'b0; cyc();

    // 5: rejected loads, then cascade-mode level counting on MOD=24
    do_load(4'd6, 4'd0);
    chk("t5_err_60", 32'(load_err), 32'd1);
    chk("t5_held", 32'(count_bin), 32'd44);
    cyc();
    chk("t5_err_pulse", 32'(load_err), 32'd0);
    do_load(4'd0, 4'hA);
    chk("t5_err_A", 32'(load_err), 32'd1);
    casc_carries = 0;
    c_up = 1'b1;
    repeat (30) begin
      cyc();
      if (c_carry === 1'b1) casc_carries++;
    end
    c_up = 1'b0;
    chk("t5_casc_val", 32'({c_digit1, c_digit0}), 32'h06);
    chk("t5_casc_carries", 32'(casc_carries), 32'd1);
    cyc();

    // 6: async reset between edges drops a pending carry and the count
    do_load(4'd5, 4'd9);
    enUP = 1'b1; cyc();
    chk("t6_carry_set", 32'(carry), 32'd1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_carry_dropped", 32'(carry), 32'd0);
    check_all();
    #3 reset = 1'b1;
    cyc();
    enUP = 1'b0;
    do_load(4'd3, 4'd7);
    enUP = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_digits_cleared", 32'({digit1, digit0}), 32'h00);
    check_all();
    #3 reset = 1'b1;
    enUP = 1'b0;
    cyc();

    // Random soak over ticks and loads (legal and illegal digits)
    repeat (400) begin
      enUP   = 1'($urandom_range(0, 1));
      enDOWN = 1'($urandom_range(0, 1));
      load   = ($urandom_range(0, 7) == 0);
      load_d1 = 4'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 9 : 15));
      load_d0 = 4'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 9 : 15));
      c_up   = 1'($urandom_range(0, 1));
      c_dn   = 1'($urandom_range(0, 1));
      c_ld   = ($urandom_range(0, 7) == 0);
      c_d1   = 4'($urandom_range(0, 3));
      c_d0   = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
